// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    WR_COLLECT,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Number of byte-offset address bits dropped to form a register index.
  function automatic int idx_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle between interconnect (master) and register bank (slave).
interface axi_lite_regbank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_strb_merge.sv
// Byte-lane merge of an old register word with new write data under WSTRB.
module axi_lite_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_word,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);
  for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_byte
    assign merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
  end
endmodule

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite slave register bank with read-only hardware-fed
// registers, per-register write pulses and SLVERR signalling.
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  axi_lite_regbank_if.slave                    bus,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  reg_out,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  hw_in,
  output logic [NUM_REGS-1:0]                  wr_pulse
);
  localparam int SHIFT = idx_shift(DATA_WIDTH);
  localparam int IW    = ADDR_WIDTH - SHIFT;
  localparam int SW    = DATA_WIDTH / 8;

  wr_state_t                           wr_state_q, wr_state_d;
  rd_state_t                           rd_state_q, rd_state_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d, merged;
  logic [NUM_REGS-1:0]                 wr_sel, wr_pulse_q, wr_pulse_d;
  logic [IW-1:0]                       aw_idx_q, aw_idx_d, ar_idx;
  logic [DATA_WIDTH-1:0]               wdata_q, wdata_d, rdata_q, rdata_d, rd_val;
  logic [SW-1:0]                       wstrb_q, wstrb_d;
  logic                                aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                                awready_q, awready_d, wready_q, wready_d;
  logic                                bvalid_q, bvalid_d, arready_q, arready_d;
  logic                                rvalid_q, rvalid_d, rd_hit;
  resp_t                               bresp_q, bresp_d, rresp_q, rresp_d;
  logic                                unused_ok;

  // Per-register lane: strobe merge and write-select decode.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_lane
    axi_lite_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
      .old_word (regs_q[i]),
      .new_word (wdata_q),
      .strb     (wstrb_q),
      .merged   (merged[i])
    );
    assign wr_sel[i] = (32'(aw_idx_q) == i) && !RO_MASK[i];
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    unique case (wr_state_q)
      WR_COLLECT: begin
        if (aw_held_q && w_held_q) begin
          wr_state_d = WR_RESP;
          bvalid_d   = 1'b1;
          if (|wr_sel) begin
            bresp_d    = OKAY;
            wr_pulse_d = wr_sel;
            for (int i = 0; i < NUM_REGS; i++)
              if (wr_sel[i]) regs_d[i] = merged[i];
          end else begin
            bresp_d = SLVERR;
          end
        end else begin
          if (bus.AWVALID && awready_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = bus.AWADDR[ADDR_WIDTH-1:SHIFT];
          end
          if (bus.WVALID && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = bus.WDATA;
            wstrb_d  = bus.WSTRB;
          end
        end
      end
      WR_RESP: begin
        if (bus.BREADY) begin
          wr_state_d = WR_COLLECT;
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
    endcase
    // Readies are registered so each one drops on the edge that captures its channel.
    awready_d = (wr_state_d == WR_COLLECT) && !aw_held_d;
    wready_d  = (wr_state_d == WR_COLLECT) && !w_held_d;
  end

  always_comb begin
    ar_idx = bus.ARADDR[ADDR_WIDTH-1:SHIFT];
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(ar_idx) == i) begin
        rd_hit = 1'b1;
        rd_val = RO_MASK[i] ? hw_in[i] : regs_q[i];
      end
    end
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (bus.ARVALID && arready_q) begin
          rd_state_d = RD_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = rd_val;
          rresp_d    = rd_hit ? OKAY : SLVERR;
        end
      end
      RD_DATA: begin
        if (bus.RREADY) begin
          rd_state_d = RD_IDLE;
          arready_d  = 1'b1;
          rvalid_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= WR_COLLECT;
      rd_state_q <= RD_IDLE;
      regs_q     <= '0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      wr_pulse_q <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      regs_q     <= regs_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;
  assign reg_out     = regs_q;
  assign wr_pulse    = wr_pulse_q;

  // Byte-offset bits are ignored; hw_in slices of writable registers are never read.
  assign unused_ok = ^{bus.AWADDR[SHIFT-1:0], bus.ARADDR[SHIFT-1:0], hw_in};
endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed + randomized bench for axi_lite_regbank against an array-based register model.
module tb_axi_lite_regbank;
  localparam int          NR = 16;
  localparam logic [15:0] RO = 16'h8000;

  logic                 ACLK = 1'b0;
  logic                 ARESET = 1'b1;
  logic [NR-1:0][31:0]  reg_out;
  logic [NR-1:0][31:0]  hw_in;
  logic [NR-1:0]        wr_pulse;
  int                   vectors = 0;
  int                   miscompares = 0;
  logic [31:0]          m_regs [NR];

  axi_lite_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  axi_lite_regbank #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(NR), .RO_MASK(RO)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .bus      (bus),
    .reg_out  (reg_out),
    .hw_in    (hw_in),
    .wr_pulse (wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [511:0] m_pack();
    logic [511:0] r;
    for (int i = 0; i < NR; i++) r[32*i +: 32] = m_regs[i];
    return r;
  endfunction

  // Full write transaction; W leads AW by w_lead cycles, BREADY withheld b_hold cycles.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w_lead, input int b_hold);
    int          idx, n;
    bit          ok, aw_done, w_done, aw_hs, w_hs;
    logic [1:0]  exp_resp;
    logic [15:0] exp_pulse;
    idx       = int'(a) / 4;
    ok        = (idx < NR) && (RO[idx] == 1'b0);
    exp_resp  = ok ? 2'b00 : 2'b10;
    exp_pulse = ok ? (16'b1 << idx) : 16'b0;
    bus.AWADDR  = a;
    bus.WDATA   = d;
    bus.WSTRB   = s;
    bus.WVALID  = 1'b1;
    bus.AWVALID = (w_lead == 0);
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      tick(); n++;
      if (aw_hs) begin aw_done = 1; bus.AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.WVALID  = 1'b0; end
      if (!aw_done && n >= w_lead) bus.AWVALID = 1'b1;
      if (w_done && !aw_done) begin
        check("wready_after_w", bus.WREADY, 0);
        check("awready_wait_aw", bus.AWREADY, 1);
        check("bvalid_before_aw", bus.BVALID, 0);
      end
    end
    check("wr_hs_timeout", n < 50, 1);
    check("bvalid_at_hs_edge", bus.BVALID, 0);
    tick();
    check("bvalid_commit", bus.BVALID, 1);
    check("bresp", bus.BRESP, exp_resp);
    check("wr_pulse", wr_pulse, exp_pulse);
    if (ok)
      for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
    check("reg_out", reg_out, m_pack());
    for (int k = 0; k < b_hold; k++) begin
      tick();
      check("bvalid_hold", bus.BVALID, 1);
      check("bresp_hold", bus.BRESP, exp_resp);
      check("awready_in_resp", bus.AWREADY, 0);
      check("wready_in_resp", bus.WREADY, 0);
      check("wr_pulse_one_cycle", wr_pulse, 0);
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    check("bvalid_cleared", bus.BVALID, 0);
    check("awready_back", bus.AWREADY, 1);
    check("wready_back", bus.WREADY, 1);
    check("wr_pulse_cleared", wr_pulse, 0);
  endtask

  task automatic do_read(input logic [7:0] a, input int r_hold);
    int         idx, n;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    idx = int'(a) / 4;
    if (idx >= NR)   begin exp_d = '0;         exp_r = 2'b10; end
    else if (RO[idx]) begin exp_d = hw_in[idx]; exp_r = 2'b00; end
    else             begin exp_d = m_regs[idx]; exp_r = 2'b00; end
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 50) begin tick(); n++; end
    check("ar_timeout", n < 50, 1);
    tick();
    bus.ARVALID = 1'b0;
    check("rvalid", bus.RVALID, 1);
    check("rdata", bus.RDATA, exp_d);
    check("rresp", bus.RRESP, exp_r);
    check("arready_in_data", bus.ARREADY, 0);
    for (int k = 0; k < r_hold; k++) begin
      tick();
      check("rvalid_hold", bus.RVALID, 1);
      check("rdata_hold", bus.RDATA, exp_d);
      check("rresp_hold", bus.RRESP, exp_r);
      check("arready_hold", bus.ARREADY, 0);
    end
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    check("rvalid_cleared", bus.RVALID, 0);
    check("arready_back", bus.ARREADY, 1);
  endtask

  initial begin
    logic [31:0] d;
    int          idx;
    bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0;
    bus.BREADY = 0;  bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
    hw_in = '0;
    hw_in[15] = 32'hCAFE0001;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;

    // Reset state
    ARESET = 1'b1;
    tick(); tick();
    check("rst_awready", bus.AWREADY, 0);
    check("rst_arready", bus.ARREADY, 0);
    check("rst_bvalid", bus.BVALID, 0);
    check("rst_rdata", bus.RDATA, 0);
    check("rst_reg_out", reg_out, 0);
    ARESET = 1'b0;
    tick();
    check("rdy_after_rst_aw", bus.AWREADY, 1);
    check("rdy_after_rst_w", bus.WREADY, 1);
    check("rdy_after_rst_ar", bus.ARREADY, 1);

    // Directed cases
    do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(8'h04, 0);
    do_write(8'h04, 32'h11223344, 4'h5, 0, 0);
    check("strb_merge_model", m_regs[1], 32'hDE22BE44);
    do_read(8'h04, 0);
    do_write(8'h08, 32'h0BADF00D, 4'hF, 3, 0);
    do_write(8'h40, 32'h12345678, 4'hF, 0, 0);
    do_read(8'h40, 0);
    do_write(8'h3C, 32'h55555555, 4'hF, 0, 0);
    do_read(8'h3C, 0);
    do_write(8'h0C, 32'hA5A5A5A5, 4'hF, 0, 5);
    do_read(8'h0C, 5);

    // Read sampled on the commit edge of a write to the same register
    d = $urandom;
    bus.AWADDR = 8'h08; bus.WDATA = d; bus.WSTRB = 4'hF;
    bus.AWVALID = 1; bus.WVALID = 1; bus.ARADDR = 8'h08;
    tick();
    bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 1;
    tick();
    bus.ARVALID = 0;
    check("collide_old_value", bus.RDATA, m_regs[2]);
    check("collide_bvalid", bus.BVALID, 1);
    m_regs[2] = d;
    check("collide_reg_out", reg_out, m_pack());
    bus.BREADY = 1; bus.RREADY = 1;
    tick();
    bus.BREADY = 0; bus.RREADY = 0;

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      hw_in = {NR{$urandom}};
      idx = $urandom_range(0, 19);
      if ($urandom_range(0, 1) == 1)
        do_write({idx[5:0], 2'($urandom)}, $urandom, 4'($urandom), $urandom_range(0, 2),
                 $urandom_range(0, 2));
      else
        do_read({idx[5:0], 2'($urandom)}, $urandom_range(0, 2));
    end

    // Reset while both response channels are pending
    bus.AWADDR = 8'h10; bus.WDATA = 32'hFFFFFFFF; bus.WSTRB = 4'hF;
    bus.AWVALID = 1; bus.WVALID = 1; bus.ARADDR = 8'h04; bus.ARVALID = 1;
    tick();
    bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
    tick();
    check("pre_rst_bvalid", bus.BVALID, 1);
    check("pre_rst_rvalid", bus.RVALID, 1);
    ARESET = 1'b1;
    tick();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    check("mid_rst_bvalid", bus.BVALID, 0);
    check("mid_rst_rvalid", bus.RVALID, 0);
    check("mid_rst_bresp", bus.BRESP, 0);
    check("mid_rst_rdata", bus.RDATA, 0);
    check("mid_rst_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 0);
    check("mid_rst_reg_out", reg_out, m_pack());
    check("mid_rst_wr_pulse", wr_pulse, 0);
    ARESET = 1'b0;
    tick();
    check("post_rst_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    do_read(8'h04, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
